// File: rtl/e_mdu_issue.sv
// rtl/e_mdu_issue.sv - E-stage issue controller for the MDU start/busy protocol (optional check: MDU_ISSUE_CHECK_EN)
module e_mdu_issue #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    input  logic        mdu_busy,
    output logic        mdu_start,
    output logic [2:0]  mdu_op,
    output logic [31:0] mdu_d1,
    output logic [31:0] mdu_d2,
    output logic        stall,
    output logic        mdu_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    state_t     state;
    logic [3:0] cnt;
    logic       hilo;
    logic       is_mul;
    logic       is_div;

    assign hilo   = req_valid && (req_op != 3'd0);
    assign is_mul = (req_op == 3'd1) || (req_op == 3'd2);
    assign is_div = (req_op == 3'd3) || (req_op == 3'd4);

    // Stall any HI/LO-class instruction while our shadow counter or the responder says busy
    always_comb begin
        stall = hilo && ((cnt != 4'd0) || mdu_busy);
    end

    // Present the command in the same cycle the instruction sits in E; zero everything otherwise
    always_comb begin
        mdu_start = 1'b0;
        mdu_op    = 3'd0;
        mdu_d1    = 32'd0;
        mdu_d2    = 32'd0;
        if (hilo && !stall) begin
            if (is_mul || is_div) begin
                mdu_start = 1'b1;
                mdu_op    = req_op;
                mdu_d1    = req_rs;
                mdu_d2    = req_rt;
            end else if ((req_op == 3'd5) || (req_op == 3'd6)) begin
                mdu_op    = req_op;
                mdu_d1    = req_rs;
            end
        end
    end

    // Shadow of the MDU latency: load on a start from IDLE, count down to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_start && is_mul) begin
                        state <= MUL;
                        cnt   <= MUL_LOAD;
                    end else if (mdu_start && is_div) begin
                        state <= DIV;
                        cnt   <= DIV_LOAD;
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef MDU_ISSUE_CHECK_EN
    logic exp_busy;
    logic err_q;

    // Expected responder busy follows the shadow counter; any disagreement latches until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_busy <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                exp_busy <= mdu_start;
            end else begin
                exp_busy <= (cnt > 4'd1);
            end
            if (mdu_busy != exp_busy) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mdu_err = err_q;
`else
    assign mdu_err = 1'b0;
`endif

endmodule

// File: tb/tb_e_mdu_issue.sv
// tb/tb_e_mdu_issue.sv - table-driven self-checking bench for e_mdu_issue
module tb_e_mdu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        mdu_busy;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_d1;
    logic [31:0] mdu_d2;
    logic        stall;
    logic        mdu_err;

    logic        busy_force;
    logic [3:0]  resp_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e_mdu_issue dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_rs    (req_rs),
        .req_rt    (req_rt),
        .mdu_busy  (mdu_busy),
        .mdu_start (mdu_start),
        .mdu_op    (mdu_op),
        .mdu_d1    (mdu_d1),
        .mdu_d2    (mdu_d2),
        .stall     (stall),
        .mdu_err   (mdu_err)
    );

    // Responder model: busy for 5 (mult) or 10 (div) cycles after the start edge
    always @(posedge clk) begin
        if (reset) begin
            resp_cnt <= 4'd0;
        end else if (mdu_start) begin
            resp_cnt <= (mdu_op <= 3'd2) ? 4'd5 : 4'd10;
        end else if (resp_cnt != 4'd0) begin
            resp_cnt <= resp_cnt - 4'd1;
        end
    end

    assign mdu_busy = (resp_cnt != 4'd0) || busy_force;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        e_start;
        logic [2:0]  e_op;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic        e_stall;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        req_valid = v;
        req_op    = op;
        req_rs    = rs;
        req_rt    = rt;
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        busy_force = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Hold current inputs, counting stalled cycles until the instruction proceeds (bounded)
    task automatic count_stall(output int n);
        n = 0;
        while (stall && n < 40) begin
            tick();
            #1;
            n++;
        end
    endtask

    int n;

    initial begin
        reset      = 1'b1;
        busy_force = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_rs     = 32'd0;
        req_rt     = 32'd0;

        vecs[0] = '{1'b0, 3'd1, 32'd5,         32'd6,         1'b0, 3'd0, 32'd0,         32'd0,         1'b0};
        vecs[1] = '{1'b1, 3'd0, 32'd5,         32'd6,         1'b0, 3'd0, 32'd0,         32'd0,         1'b0};
        vecs[2] = '{1'b1, 3'd1, 32'd3,         32'hFFFFFFFE,  1'b1, 3'd1, 32'd3,         32'hFFFFFFFE,  1'b0};
        vecs[3] = '{1'b1, 3'd2, 32'hA5A5A5A5,  32'h12345678,  1'b1, 3'd2, 32'hA5A5A5A5,  32'h12345678,  1'b0};
        vecs[4] = '{1'b1, 3'd3, 32'd100,       32'd0,         1'b1, 3'd3, 32'd100,       32'd0,         1'b0};
        vecs[5] = '{1'b1, 3'd4, 32'hFFFFFFFF,  32'd1,         1'b1, 3'd4, 32'hFFFFFFFF,  32'd1,         1'b0};
        vecs[6] = '{1'b1, 3'd5, 32'h0000DEAD,  32'h1234,      1'b0, 3'd5, 32'h0000DEAD,  32'd0,         1'b0};
        vecs[7] = '{1'b1, 3'd6, 32'h0000BEEF,  32'd77,        1'b0, 3'd6, 32'h0000BEEF,  32'd0,         1'b0};
        vecs[8] = '{1'b1, 3'd7, 32'd11,        32'd22,        1'b0, 3'd0, 32'd0,         32'd0,         1'b0};

        do_reset();
        check("reset_outputs", {mdu_start, mdu_op, mdu_d1, mdu_d2, stall, mdu_err}, 70'd0);
        check("reset_cnt", dut.cnt, 4'd0);

        // Single-cycle issue decode from idle
        for (int i = 0; i < 9; i++) begin
            do_reset();
            drive(vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rt);
            check($sformatf("vec%0d_start_op_d1_d2_stall", i),
                  {mdu_start, mdu_op, mdu_d1, mdu_d2, stall},
                  {vecs[i].e_start, vecs[i].e_op, vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_stall});
        end

        // mult then mflo: 5-cycle stall window
        do_reset();
        drive(1'b1, 3'd1, 32'd3, 32'hFFFFFFFE);
        check("mult_issue", {mdu_start, mdu_op, mdu_d1, mdu_d2}, {1'b1, 3'd1, 32'd3, 32'hFFFFFFFE});
        tick();
        drive(1'b1, 3'd7, 32'd0, 32'd0);
        count_stall(n);
        check("mflo_stall_cycles", n, 5);
        check("mflo_proceeds", {stall, mdu_start, mdu_op}, 5'd0);
        check("mult_err", mdu_err, 1'b0);

        // divu back-to-back: second waits 10 cycles, then issues, and reloads 10
        do_reset();
        drive(1'b1, 3'd4, 32'd7, 32'd2);
        check("divu1_start", {mdu_start, mdu_op}, {1'b1, 3'd4});
        tick();
        drive(1'b1, 3'd4, 32'd9, 32'd4);
        check("divu2_start_blocked", {stall, mdu_start}, 2'b10);
        count_stall(n);
        check("divu2_stall_cycles", n, 10);
        check("divu2_issue", {mdu_start, mdu_op, mdu_d1, mdu_d2}, {1'b1, 3'd4, 32'd9, 32'd4});
        tick();
        check("divu2_cnt_reload", dut.cnt, 4'd10);
        drive(1'b1, 3'd7, 32'd0, 32'd0);
        count_stall(n);
        check("divu2_window", n, 10);

        // mthi behind multu
        do_reset();
        drive(1'b1, 3'd2, 32'd4, 32'd5);
        tick();
        drive(1'b1, 3'd5, 32'h0000DEAD, 32'h55);
        count_stall(n);
        check("mthi_stall_cycles", n, 5);
        check("mthi_issue", {mdu_start, mdu_op, mdu_d1, mdu_d2}, {1'b0, 3'd5, 32'h0000DEAD, 32'd0});

        // Non-MDU work and bubbles never stall during a div
        do_reset();
        drive(1'b1, 3'd3, 32'd50, 32'd7);
        tick();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) drive(1'b1, 3'd0, 32'd1, 32'd2);
            else            drive(1'b0, 3'd3, 32'd1, 32'd2);
            check($sformatf("nonmdu_nostall_%0d", i), {stall, mdu_start}, 2'b00);
            tick();
        end

        // Reset mid-div, then a mult issues at once
        do_reset();
        drive(1'b1, 3'd3, 32'd20, 32'd3);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("midreset_cnt", dut.cnt, 4'd0);
        drive(1'b1, 3'd1, 32'd6, 32'd7);
        check("midreset_mult", {stall, mdu_start, mdu_op}, {1'b0, 1'b1, 3'd1});

        // External busy while idle stalls and (with the check built) latches mdu_err
        do_reset();
        busy_force = 1'b1;
        drive(1'b1, 3'd1, 32'd1, 32'd1);
        check("extbusy_stall", {stall, mdu_start}, 2'b10);
        tick();
        busy_force = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
`ifdef MDU_ISSUE_CHECK_EN
        check("err_set", mdu_err, 1'b1);
        tick();
        tick();
        check("err_held", mdu_err, 1'b1);
`else
        check("err_tied", mdu_err, 1'b0);
        tick();
        tick();
        check("err_tied_held", mdu_err, 1'b0);
`endif
        do_reset();
        check("err_cleared", mdu_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e_mdu_issue.md
# e_mdu_issue

Execute-stage issue controller for the multiply/divide unit. It is the initiator side of the MDU start/busy protocol. It accepts one HI/LO-class instruction per cycle from the E stage and drives the MDU's start, op and operand lines. It tracks the MDU's fixed latency with its own shadow counter and raises a pipeline stall whenever an HI/LO-class instruction would conflict with an operation still in flight.

## Interface
- MUL_CYCLES, 5, cycles from start edge until result commit for mult/multu
- DIV_CYCLES, 10, cycles from start edge until result commit for div/divu
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  E-stage instruction present and not a bubble
- req_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi/mflo
- req_rs  in  32  forwarded rs value
- req_rt  in  32  forwarded rt value
- mdu_busy  in  1  busy from the MDU responder
- mdu_start  out  1  one-cycle start pulse to the MDU
- mdu_op  out  3  MDU op; same code space as req_op, codes 0–6 only
- mdu_d1  out  32  operand 1 (rs)
- mdu_d2  out  32  operand 2 (rt)
- stall  out  1  freeze F/D/E, insert bubble into M
- mdu_err  out  1  sticky protocol-mismatch flag; see Configuration

## Operation
- The instruction is HI/LO-class when req_valid=1 and req_op is 1–7.
- Internal state is `IDLE`, `MUL` or `DIV`, plus a counter `cnt` (4 bits, width sufficient for DIV_CYCLES).
- **Stall (combinational):** `stall = HI/LO-class & (cnt != 0 | mdu_busy)`.
- **Issue (combinational, only when HI/LO-class and stall=0):**
  - op 1–4: mdu_start=1, mdu_op=req_op, mdu_d1=req_rs, mdu_d2=req_rt.
  - op 5/6: mdu_start=0, mdu_op=req_op, mdu_d1=req_rs, mdu_d2=0.
  - op 7: no MDU command; mdu_op=0.
- **Idle outputs:** in all other cycles, mdu_start=0, mdu_op=0, mdu_d1=0, mdu_d2=0.
- **Transitions at the clock edge:**
  - `IDLE` → `MUL`, cnt ← MUL_CYCLES, when mdu_start=1 and op 1/2.
  - `IDLE` → `DIV`, cnt ← DIV_CYCLES, when mdu_start=1 and op 3/4.
  - `MUL`/`DIV`: cnt ← cnt−1 each edge; → `IDLE` on the edge where cnt goes 1→0.
- mdu_start cannot be asserted outside `IDLE`, because stall blocks it.
- Operands are passed straight through, not registered. The MDU samples them on the same edge as mdu_start.
- Division by zero is not special-cased here. The MDU result is undefined and the controller's timing is unchanged.

## Timing
- **Reset values:** state `IDLE`, cnt=0, mdu_err=0. All combinational outputs evaluate to 0 when req_valid=0.
- **Issue latency:** 0 cycles. The start is presented in the same cycle the instruction is in E.
- **Stall window:**
  - mult/multu: MUL_CYCLES cycles following the start edge.
  - div/divu: DIV_CYCLES cycles following the start edge.
  - After that, cnt=0 and the responder's busy has dropped on the same edge.
- **Boundary, cnt reaching 0:** an HI/LO-class instruction arriving in the first cycle with cnt=0 is not stalled. A new start may issue in that cycle.
- **Non-MDU instructions:** req_op=0 or req_valid=0 never stall, even while busy.
- **Back-to-back starts:** the second start is stalled for the full window, then issues on the first free cycle.
- **mthi/mtlo or mf during busy:** stalled until free. This guarantees a pending result can never overwrite a later mthi/mtlo.
- **Reset mid-operation:** state `IDLE` and cnt=0 on the next edge. mdu_busy is expected to be 0 from the same edge, since the responder resets too.
- **External busy:** mdu_busy=1 while cnt=0 still stalls (conservative OR).

## Configuration
- Macro `MDU_ISSUE_CHECK_EN`.
- **Defined:** a registered `exp_busy` tracks `cnt != 0` from the start edge onward. mdu_err is set and held until reset when mdu_busy != exp_busy in any cycle after reset.
- **Undefined:** no check logic; mdu_err tied to 0.

## Test plan
- **mult issue and window:** reset, then mult rs=3, rt=−2. Expect mdu_start=1 with op=1, d1=3, d2=0xFFFFFFFE in that cycle. A following mflo is stalled exactly 5 cycles, then proceeds; mdu_err=0.
- **divu back-to-back:** divu 7/2, then divu 9/4. Expect the second stalled 10 cycles, with start asserted on cycle 11. cnt reloads 10.
- **mthi during multu:** multu, then mthi rs=0xDEAD. Expect mthi stalled 5 cycles, then mdu_op=5, d1=0xDEAD, start=0.
- **No stall for non-MDU work:** a non-MDU instruction (req_op=0) and a bubble (req_valid=0) during div: stall=0 every cycle.
- **Reset mid-operation:** reset at cycle 3 of a div. Expect cnt=0, state `IDLE` next cycle; a new mult issues without stall.
- **Busy-mismatch check:** with MDU_ISSUE_CHECK_EN, force mdu_busy=1 for one cycle while idle. Expect mdu_err=1, held until reset.
